risc_v_multicycle_controller: RTL and testbench

Multi-cycle control unit for the RV32I subset datapath: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It replaces the single-cycle controller in the multi-cycle core and adds:

- a memory ready handshake;
- an instructions-retired counter;
- sticky illegal-instruction trapping.

---
 rtl/risc_v_pkg.sv | 50 +++++
 rtl/risc_v_alu_decoder.sv | 30 +++
 rtl/risc_v_multicycle_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_risc_v_multicycle_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_pkg.sv
// Shared definitions for the RV32I multi-cycle control path.
// Holds the opcode constants, the controller state enum, the mux and ALU control
// encodings, and the immediate-format lookup used in DECODE.
package risc_v_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
        S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_JALR_WB, S_LUI, S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
        ALU_OR  = 3'b011, ALU_XOR = 3'b100, ALU_SLT = 3'b101
    } alu_ctl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10, RES_IMMEXT = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} src_a_e;
    typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} src_b_e;

    // Operation class fed to the ALU decoder: forced add, R-type or I-type.
    typedef enum logic [1:0] {ALU_CLS_ADD = 2'b00, ALU_CLS_R = 2'b01, ALU_CLS_I = 2'b10} alu_cls_e;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_for_op(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/risc_v_alu_decoder.sv
// Combinational ALU decode shared with the single-cycle controller.
// Ports: alu_cls (forced add / R / I), func3, func7 (instr[30]) in;
//        alu_control and legal (func3 supported for R/I) out.
module risc_v_alu_decoder
    import risc_v_pkg::*;
(
    input  logic [1:0] alu_cls,
    input  logic [2:0] func3,
    input  logic       func7,
    output logic [2:0] alu_control,
    output logic       legal
);

    // func7 selects subtract only for register-register ops; addi ignores it.
    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
        if (alu_cls != ALU_CLS_ADD) begin
            case (func3)
                3'b000:  alu_control = (alu_cls == ALU_CLS_R && func7) ? ALU_SUB : ALU_ADD;
                3'b111:  alu_control = ALU_AND;
                3'b110:  alu_control = ALU_OR;
                3'b100:  alu_control = ALU_XOR;
                3'b010:  alu_control = ALU_SLT;
                default: legal       = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/risc_v_multicycle_controller.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and single memory port, with a memory ready handshake, a
// retired-instruction counter and a sticky illegal-instruction trap.
// Ports: clk, rst_n; op, func3, func7, zero, b31, mem_ready in;
//        datapath controls (combinational from state and inputs), illegal and
//        instret (registered) out.
module risc_v_multicycle_controller
    import risc_v_pkg::*;
#(
    parameter int unsigned CNT_W         = 32,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic             zero,
    input  logic             b31,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [2:0]       imm_src,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             ready, retire;
    logic             pc_write_c, ir_write_c, mem_write_c, reg_write_c;
    logic [1:0]       alu_cls;
    logic [2:0]       dec_alu_ctl;
    logic             dec_legal;
    logic             br_taken, br_legal;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    assign alu_cls = (state_q == S_EXEC_R) ? ALU_CLS_R :
                     (state_q == S_EXEC_I) ? ALU_CLS_I : ALU_CLS_ADD;

    risc_v_alu_decoder u_alu_dec (
        .alu_cls     (alu_cls),
        .func3       (func3),
        .func7       (func7),
        .alu_control (dec_alu_ctl),
        .legal       (dec_legal)
    );

    // Branch condition from the rs1 - rs2 flags.
    always_comb begin
        br_taken = 1'b0;
        br_legal = 1'b1;
        case (func3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
            3'b100:  br_taken = b31;
            3'b101:  br_taken = ~b31;
            default: br_legal = 1'b0;
        endcase
    end

    // Next state and datapath controls.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_ADD;
        imm_src     = IMM_I;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (ready) begin
                    pc_write_c = 1'b1;
                    ir_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jal target is computed here and parked in ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = imm_for_op(op);
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src  = RES_DATA;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WR: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                if (ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                alu_control = dec_alu_ctl;
                state_d     = dec_legal ? S_ALU_WB : S_TRAP;
            end
            S_ALU_WB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = ALU_SUB;
                if (br_legal) begin
                    pc_write_c = br_taken;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_JAL: begin
                // Jump to the parked target while computing the link value.
                pc_write_c = 1'b1;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                state_d    = S_ALU_WB;
            end
            S_JALR: begin
                if (func3 == 3'b000) begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    result_src = RES_ALURESULT;
                    pc_write_c = 1'b1;
                    state_d    = S_JALR_WB;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_JALR_WB: begin
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALURESULT;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_LUI: begin
                imm_src     = IMM_U;
                result_src  = RES_IMMEXT;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_TRAP);
            instret_q <= instret_d;
        end
    end

    // Write enables are masked while reset is held so an abandoned
    // instruction cannot commit anything.
    assign pc_write  = pc_write_c & rst_n;
    assign ir_write  = ir_write_c & rst_n;
    assign mem_write = mem_write_c & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign illegal   = illegal_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_risc_v_multicycle_controller.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle
// control schedule, driven cycle by cycle and compared against the controller.
module tb_risc_v_multicycle_controller;

    localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011;
    localparam logic [6:0] T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111;
    localparam logic [6:0] T_JALR = 7'b1100111, T_LUI = 7'b0110111;
    localparam logic [6:0] OPS [8] = '{T_LOAD, T_STORE, T_R, T_I, T_BR, T_JAL, T_JALR, T_LUI};

    // Control vector layout: {pcw,adr,irw,mrd,mwr}_{result}_{srcA}_{srcB}_{alu}_{imm}_{regw}
    localparam logic [17:0] FE_WAIT = 18'b00010_10_00_10_000_000_0;
    localparam logic [17:0] FE_GO   = 18'b10110_10_00_10_000_000_0;
    localparam logic [17:0] MADR    = 18'b00000_00_10_01_000_000_0;
    localparam logic [17:0] MRD     = 18'b01010_00_00_00_000_000_0;
    localparam logic [17:0] MWB     = 18'b00000_01_00_00_000_000_1;
    localparam logic [17:0] MWR     = 18'b01001_00_00_00_000_000_0;
    localparam logic [17:0] AWB     = 18'b00000_00_00_00_000_000_1;
    localparam logic [17:0] VJAL    = 18'b10000_00_01_10_000_000_0;
    localparam logic [17:0] VJALR   = 18'b10000_10_10_01_000_000_0;
    localparam logic [17:0] JWB     = 18'b00000_10_01_10_000_000_1;
    localparam logic [17:0] VLUI    = 18'b00000_11_00_00_000_100_1;
    localparam logic [17:0] NONE    = 18'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst2_n, phase_b;
    logic [6:0] op;
    logic [2:0] func3;
    logic func7, zero, b31, mem_ready;

    logic pc_write, adr_src, ir_write, mem_read, mem_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
    logic [31:0] instret;

    logic pc_write2, adr_src2, ir_write2, mem_read2, mem_write2, reg_write2, illegal2;
    logic [1:0] result_src2, alu_src_a2, alu_src_b2;
    logic [2:0] alu_control2, imm_src2;
    logic [3:0] instret2;

    assign rst2_n = rst_n & phase_b;

    risc_v_multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .b31(b31), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write),
        .illegal(illegal), .instret(instret)
    );

    risc_v_multicycle_controller #(.CNT_W(4), .MEM_HANDSHAKE(1'b0)) dut2 (
        .clk(clk), .rst_n(rst2_n), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .b31(b31), .mem_ready(1'b0), .pc_write(pc_write2), .adr_src(adr_src2),
        .ir_write(ir_write2), .mem_read(mem_read2), .mem_write(mem_write2),
        .result_src(result_src2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
        .alu_control(alu_control2), .imm_src(imm_src2), .reg_write(reg_write2),
        .illegal(illegal2), .instret(instret2)
    );

    logic [17:0] act1, act2;
    assign act1 = {pc_write, adr_src, ir_write, mem_read, mem_write, result_src,
                   alu_src_a, alu_src_b, alu_control, imm_src, reg_write};
    assign act2 = {pc_write2, adr_src2, ir_write2, mem_read2, mem_write2, result_src2,
                   alu_src_a2, alu_src_b2, alu_control2, imm_src2, reg_write2};

    int total, bad, ncyc;
    int unsigned model_cnt;
    logic model_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    // 0 load,1 store,2 R,3 I,4 branch,5 jal,6 jalr,7 lui,8 unknown
    function automatic int op_class(input logic [6:0] o);
        for (int k = 0; k < 8; k++) if (OPS[k] == o) return k;
        return 8;
    endfunction

    function automatic logic [2:0] imm_of(input int c);
        case (c)
            1: return 3'b001;
            4: return 3'b010;
            5: return 3'b011;
            7: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'b000: return (is_r && f7) ? 3'b001 : 3'b000;
            3'b111: return 3'b010;
            3'b110: return 3'b011;
            3'b100: return 3'b100;
            3'b010: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] legal_f3(input int c);
        logic [2:0] alu_ok [5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
        logic [2:0] br_ok [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
        if (c == 2 || c == 3) return alu_ok[$urandom_range(4, 0)];
        if (c == 4) return br_ok[$urandom_range(3, 0)];
        if (c == 6) return 3'b000;
        return 3'($urandom_range(7, 0));
    endfunction

    // One controller cycle: set mem_ready, compare, advance to the next falling edge.
    task automatic cyc(input logic rdy, input logic [17:0] exp);
        mem_ready = rdy;
        #1;
        chk("ctl", 32'(act1), 32'(exp));
        chk("illegal", 32'(illegal), 32'(model_ill));
        chk("instret", instret, model_cnt);
        if (phase_b) begin
            chk("ctl2", 32'(act2), 32'(exp));
            chk("illegal2", 32'(illegal2), 32'(model_ill));
            chk("instret2", 32'(instret2), 32'(model_cnt[3:0]));
        end
        ncyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserted mid-cycle so the clears must be asynchronous.
    task automatic do_reset(input logic en_b);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        phase_b = en_b;
        model_cnt = 0;
        model_ill = 1'b0;
        #1;
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_ctl", 32'(act1), 32'(18'b00010_10_00_10_000_000_0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic trap_tail();
        model_ill = 1'b1;
        repeat (3) cyc(rbit(), NONE);
        do_reset(phase_b);
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input logic n, input int fw, input int mw);
        int c;
        logic tk, brl;
        logic [2:0] alu;
        op = o; func3 = f3; func7 = f7; zero = z; b31 = n;
        ncyc = 0;
        c = op_class(o);
        repeat (fw) cyc(1'b0, FE_WAIT);
        cyc(1'b1, FE_GO);
        cyc(rbit(), {5'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm_of(c), 1'b0});
        case (c)
            0: begin
                cyc(rbit(), MADR);
                repeat (mw) cyc(1'b0, MRD);
                cyc(1'b1, MRD);
                cyc(rbit(), MWB);
                model_cnt++;
            end
            1: begin
                cyc(rbit(), MADR);
                repeat (mw) cyc(1'b0, MWR);
                cyc(1'b1, MWR);
                model_cnt++;
            end
            2, 3: begin
                alu = alu_of(f3, f7, c == 2);
                cyc(rbit(), {5'b0, 2'b00, 2'b10, (c == 2) ? 2'b00 : 2'b01, alu, 3'b000, 1'b0});
                if (f3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010}) begin
                    cyc(rbit(), AWB);
                    model_cnt++;
                end else trap_tail();
            end
            4: begin
                brl = f3 inside {3'b000, 3'b001, 3'b100, 3'b101};
                tk = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? n : !n;
                tk = tk & brl;
                cyc(rbit(), {tk, 4'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0});
                if (brl) model_cnt++;
                else trap_tail();
            end
            5: begin
                cyc(rbit(), VJAL);
                cyc(rbit(), AWB);
                model_cnt++;
            end
            6: begin
                if (f3 == 3'b000) begin
                    cyc(rbit(), VJALR);
                    cyc(rbit(), JWB);
                    model_cnt++;
                end else begin
                    cyc(rbit(), NONE);
                    trap_tail();
                end
            end
            7: begin
                cyc(rbit(), VLUI);
                model_cnt++;
            end
            default: trap_tail();
        endcase
    endtask

    initial begin
        logic [6:0] o;
        int c;
        rst_n = 1'b0; phase_b = 1'b0; op = '0; func3 = '0; func7 = 1'b0;
        zero = 1'b0; b31 = 1'b0; mem_ready = 1'b0;
        total = 0; bad = 0; ncyc = 0; model_cnt = 0; model_ill = 1'b0;
        @(negedge clk);
        do_reset(1'b0);

        run_instr(T_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);        // add
        chk("add_cycles", 32'(ncyc), 32'd4);
        chk("add_instret", instret, 32'd1);
        run_instr(T_R, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);        // sub
        run_instr(T_BR, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0);       // beq taken
        chk("br_cycles", 32'(ncyc), 32'd3);
        run_instr(T_BR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);       // beq not taken
        run_instr(T_BR, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0);       // blt taken
        run_instr(T_BR, 3'b101, 1'b0, 1'b0, 1'b1, 0, 0);       // bge not taken
        run_instr(T_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);     // lw, 3 waits
        chk("lw_wait_cycles", 32'(ncyc), 32'd8);
        run_instr(T_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1, 2);    // sw with waits
        run_instr(T_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("jal_cycles", 32'(ncyc), 32'd4);
        run_instr(T_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(T_LUI, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("lui_cycles", 32'(ncyc), 32'd3);
        chk("dir_instret", instret, 32'd11);

        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0); // illegal opcode
        run_instr(T_R, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0);        // unsupported func3

        for (int i = 0; i < 150; i++) begin
            o = ($urandom_range(15, 0) == 0) ? 7'($urandom) : OPS[$urandom_range(7, 0)];
            c = op_class(o);
            run_instr(o, ($urandom_range(7, 0) == 0) ? 3'($urandom) : legal_f3(c),
                      rbit(), rbit(), rbit(), $urandom_range(2, 0), $urandom_range(2, 0));
        end

        // Zero-wait stream on both instances; the narrow one ignores its tied-off ready.
        do_reset(1'b1);
        run_instr(T_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("lw_cycles", 32'(ncyc), 32'd5);
        for (int i = 0; i < 16; i++) begin
            c = $urandom_range(7, 0);
            run_instr(OPS[c], legal_f3(c), rbit(), rbit(), rbit(), 0, 0);
        end
        chk("wrap4_instret", 32'(instret2), 32'd1);
        chk("cnt32_instret", instret, 32'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
